// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Two-requester write arbiter in front of a register-file write port.
//   The grant is combinational and alternates on contention. The granted
//   request becomes a one-cycle registered write. Writes to register 0 are
//   accepted but never enabled. Committed writes are counted, and the
//   counter saturates at all-ones. Hazard flags compare the read addresses
//   with the write that is currently in flight.
// Ports
//   Clk, Rst_n                        clock, async active-low reset
//   ValidA/B, AddrA/B, DataA/B        write requests from A and B
//   ReadyA/B                          grant; transfer = Valid & Ready
//   Hold                              blocks all grants while high
//   RegWrite, WriteRegister, WriteData   registered write port
//   ReadRegister1/2, Hazard1/2        read addresses and in-flight match
//   CommitCount                       saturating count of enabled writes
module regfile_write_arbiter #(
  parameter int width        = 32,
  parameter int addresswidth = 5,
  parameter int countwidth   = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    ValidA,
  input  logic [addresswidth-1:0] AddrA,
  input  logic [width-1:0]        DataA,
  output logic                    ReadyA,
  input  logic                    ValidB,
  input  logic [addresswidth-1:0] AddrB,
  input  logic [width-1:0]        DataB,
  output logic                    ReadyB,
  input  logic                    Hold,
  output logic                    RegWrite,
  output logic [addresswidth-1:0] WriteRegister,
  output logic [width-1:0]        WriteData,
  input  logic [addresswidth-1:0] ReadRegister1,
  input  logic [addresswidth-1:0] ReadRegister2,
  output logic                    Hazard1,
  output logic                    Hazard2,
  output logic [countwidth-1:0]   CommitCount
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  prio_t prio, prioNext;
  logic  grantA, grantB;

  // Grants are gated by Rst_n so that nothing is accepted during reset.
  always_comb begin
    grantA   = 1'b0;
    grantB   = 1'b0;
    prioNext = prio;
    if (Rst_n && !Hold) begin
      if (ValidA && (!ValidB || prio == PRIO_A)) grantA = 1'b1;
      else if (ValidB)                          grantB = 1'b1;
    end
    if (grantA)      prioNext = PRIO_B;
    else if (grantB) prioNext = PRIO_A;
  end

  assign ReadyA = grantA;
  assign ReadyB = grantB;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) prio <= PRIO_A;
    else        prio <= prioNext;
  end

  // Address/data load on every transfer, including transfers to register 0.
  // The enable is the only thing suppressed for register 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (grantA) begin
      RegWrite      <= (AddrA != '0);
      WriteRegister <= AddrA;
      WriteData     <= DataA;
    end else if (grantB) begin
      RegWrite      <= (AddrB != '0);
      WriteRegister <= AddrB;
      WriteData     <= DataB;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                             CommitCount <= '0;
    else if (RegWrite && CommitCount != '1) CommitCount <= CommitCount + countwidth'(1);
  end

  assign Hazard1 = RegWrite && (ReadRegister1 == WriteRegister);
  assign Hazard2 = RegWrite && (ReadRegister2 == WriteRegister);

endmodule
